// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types, op encodings and helpers for the divide sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_ITERS = 32;

  localparam logic [1:0] DIV_OP_DIV_W  = 2'b01;
  localparam logic [1:0] DIV_OP_MOD_W  = 2'b11;
  localparam logic [1:0] DIV_OP_DIV_WU = 2'b00;
  localparam logic [1:0] DIV_OP_MOD_WU = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter_step.sv
// ============================================================================
// div_iter_step : one radix-2 restoring shift-subtract iteration
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_dvd,
  input  logic [DATA_W-1:0] i_dsr,
  output logic [DATA_W-1:0] o_rem_next,
  output logic [DATA_W-1:0] o_dvd_next,
  output logic              o_q_bit
);

  logic              w_top;
  logic [DATA_W-1:0] w_low;

  // The shifted partial remainder is DATA_W+1 bits wide; a set top bit
  // guarantees it exceeds any divisor, and the modular subtract still
  // yields the correct low bits.
  assign w_top      = i_rem[DATA_W-1];
  assign w_low      = {i_rem[DATA_W-2:0], i_dvd[DATA_W-1]};
  assign o_q_bit    = w_top | (w_low >= i_dsr);
  assign o_rem_next = o_q_bit ? (w_low - i_dsr) : w_low;
  assign o_dvd_next = {i_dvd[DATA_W-2:0], o_q_bit};

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// ============================================================================
// div_seq_ctrl : multi-cycle div.w/mod.w/div.wu/mod.wu sequencer for EXE
// Optional DIV_FAST_PATH_EN: skip CALC when divisor is 0 or |src1| < |src2|.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_div_req_valid,
  output logic              o_div_req_ready,
  input  logic [1:0]        i_div_op,
  input  logic [DATA_W-1:0] i_div_src1,
  input  logic [DATA_W-1:0] i_div_src2,
  input  logic              i_div_flush,
  output logic              o_div_resp_valid,
  input  logic              i_div_resp_ready,
  output logic [DATA_W-1:0] o_div_result,
  output logic              o_div_busy
);

  import div_pkg::*;

  div_state_e        r_state, w_state_nxt;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_rem, r_dvd, r_dsr, r_result;
  logic              r_mod, r_s1neg, r_s2neg;

  logic [DATA_W-1:0] w_abs1, w_abs2, w_rem_next, w_dvd_next;
  logic [DATA_W-1:0] w_q_corr, w_r_corr, w_final, w_fast_res;
  logic              w_q_bit, w_accept, w_fast, w_last, w_neg_q;

  assign w_abs1   = div_mag(i_div_src1, i_div_op[0]);
  assign w_abs2   = div_mag(i_div_src2, i_div_op[0]);
  assign w_accept = (r_state == DIV_IDLE) && i_div_req_valid && !i_div_flush;
  assign w_last   = (r_cnt == 5'(DIV_ITERS - 1));

`ifdef DIV_FAST_PATH_EN
  assign w_fast = (i_div_src2 == '0) || (w_abs1 < w_abs2);
`else
  assign w_fast = 1'b0;
`endif

  // Quotient 0 (all-ones for a zero divisor) and the untouched dividend.
  assign w_fast_res = i_div_op[1] ? i_div_src1 : {DATA_W{i_div_src2 == '0}};

  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .i_rem      (r_rem),
    .i_dvd      (r_dvd),
    .i_dsr      (r_dsr),
    .o_rem_next (w_rem_next),
    .o_dvd_next (w_dvd_next),
    .o_q_bit    (w_q_bit)
  );

  // A zero divisor keeps the all-ones quotient unsigned-looking.
  assign w_neg_q  = (r_s1neg ^ r_s2neg) && (r_dsr != '0);
  assign w_q_corr = w_neg_q ? (~w_dvd_next + 1'b1) : w_dvd_next;
  assign w_r_corr = r_s1neg ? (~w_rem_next + 1'b1) : w_rem_next;
  assign w_final  = r_mod ? w_r_corr : w_q_corr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (w_accept) w_state_nxt = w_fast ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (w_last) w_state_nxt = DIV_DONE;
      DIV_DONE: if (i_div_resp_ready) w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
    if (i_div_flush) w_state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_result <= '0;
      r_mod    <= 1'b0;
      r_s1neg  <= 1'b0;
      r_s2neg  <= 1'b0;
    end else if (r_state == DIV_IDLE) begin
      if (w_accept) begin
        r_rem   <= '0;
        r_dvd   <= w_abs1;
        r_dsr   <= w_abs2;
        r_cnt   <= '0;
        r_mod   <= i_div_op[1];
        r_s1neg <= i_div_op[0] & i_div_src1[DATA_W-1];
        r_s2neg <= i_div_op[0] & i_div_src2[DATA_W-1];
        if (w_fast) r_result <= w_fast_res;
      end
    end else if (r_state == DIV_CALC) begin
      r_rem <= w_rem_next;
      r_dvd <= w_dvd_next;
      r_cnt <= r_cnt + 5'd1;
      if (w_last) r_result <= w_final;
    end
  end

  assign o_div_req_ready  = (r_state == DIV_IDLE);
  assign o_div_resp_valid = (r_state == DIV_DONE);
  assign o_div_busy       = (r_state != DIV_IDLE);
  assign o_div_result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// ============================================================================
// tb_div_seq_ctrl : directed table, corner sequences and random ops vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [1:0]  op;
  logic [31:0] src1, src2, result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_div_req_valid  (req_valid),
    .o_div_req_ready  (req_ready),
    .i_div_op         (op),
    .i_div_src1       (src1),
    .i_div_src2       (src2),
    .i_div_flush      (flush),
    .o_div_resp_valid (resp_valid),
    .i_div_resp_ready (resp_ready),
    .o_div_result     (result),
    .o_div_busy       (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
    logic [31:0] ma, mb;
    ma = (o[0] && a[31]) ? -a : a;
    mb = (o[0] && b[31]) ? -b : b;
    if (b == 0 || ma < mb) return 0;
`endif
    return 32;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; op = o; src1 = a; src2 = b;
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    start_req(o, a, b);
    wait_resp(lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat(o, a, b)));
    chk({name, "_result"}, 64'(result), 64'(exp));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_idle_after"}, {62'd0, req_ready, resp_valid}, 64'b10);
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2};
    vecs[1]  = '{2'b11, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'd10,         32'h0000_0005};
    vecs[3]  = '{2'b00, 32'd1234,      32'd0,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'd1234,      32'd0,          32'd1234};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000};
    vecs[6]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000};
    vecs[7]  = '{2'b00, 32'd3,         32'd9,          32'd0};
    vecs[8]  = '{2'b10, 32'd3,         32'd9,          32'd3};
    vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 32'h8000_0001,  32'd1};
    vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0001,  32'h7FFF_FFFE};
    vecs[11] = '{2'b01, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2};
    vecs[12] = '{2'b11, 32'd100,       32'hFFFF_FFF9,  32'd2};

    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    op = 2'b00; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", {req_ready, resp_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'd0});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Backpressure: result must hold while EXE is not ready.
    start_req(2'b01, 32'hFFFF_FF9C, 32'd7);
    wait_resp(lat);
    chk("bp_latency", 64'(lat), 64'(exp_lat(2'b01, 32'hFFFF_FF9C, 32'd7)));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", {resp_valid, req_ready, result}, {1'b1, 1'b0, 32'hFFFF_FFF2});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_release_idle", {62'd0, req_ready, resp_valid}, 64'b10);
    start_req(2'b10, 32'hFFFF_FFFF, 32'd10);
    chk("bp_next_accepted", 64'(busy), 64'd1);
    wait_resp(lat);
    chk("bp_next_result", 64'(result), 64'd5);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Flush at iteration 15 with a competing request.
    start_req(2'b00, 32'hFFFF_0000, 32'd3);
    repeat (15) @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op = 2'b00; src1 = 32'd50; src2 = 32'd5;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle", {61'd0, req_ready, resp_valid, busy}, 64'b100);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid || busy) lat++;
    end
    chk("flush_no_resp", 64'(lat), 64'd0);

    // Same with reset instead of flush.
    start_req(2'b01, 32'hFFFF_FF9C, 32'd7);
    repeat (15) @(negedge clk);
    reset = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk("reset_mid_calc", {req_ready, resp_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'd0});
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid || busy) lat++;
    end
    chk("reset_no_resp", 64'(lat), 64'd0);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", n), ro, ra, rb, model(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
